// File: rtl/riscv_sig_dumper.sv
// Signature dumper: reads the compliance signature range over a bus host port
// and streams the words out through a small response FIFO.

module riscv_sig_dumper #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int FifoDepth = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] begin_addr_i,
  input  logic [AddrWidth-1:0] end_addr_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 host_req_o,
  input  logic                 host_gnt_i,
  output logic [AddrWidth-1:0] host_addr_o,
  output logic                 host_we_o,
  output logic [3:0]           host_be_o,
  output logic [DataWidth-1:0] host_wdata_o,
  input  logic                 host_rvalid_i,
  input  logic [DataWidth-1:0] host_rdata_i,
  input  logic                 host_err_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth-1:0] out_data_o,
  output logic                 out_last_o
);

  localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int CntW = PtrW + 1;
  localparam logic [AddrWidth-1:0] AlignMask = {{(AddrWidth-2){1'b1}}, 2'b00};
  localparam logic [AddrWidth-1:0] WordStep  = AddrWidth'(3'd4);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                state_r;
  state_e                state_next_s;
  logic [AddrWidth-1:0]  rd_addr_r;
  logic [AddrWidth-1:0]  stop_addr_r;
  logic [CntW-1:0]       outstanding_r;
  logic [CntW-1:0]       fifo_count_r;
  logic [PtrW-1:0]       wptr_r;
  logic [PtrW-1:0]       rptr_r;
  logic [DataWidth-1:0]  mem_r [FifoDepth];
  logic                  err_r;

  logic [AddrWidth-1:0]  begin_aligned_s;
  logic [AddrWidth-1:0]  end_aligned_s;
  logic [CntW:0]         inflight_s;
  logic                  credit_ok_s;
  logic                  start_ok_s;
  logic                  grant_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  last_grant_s;
  logic                  fifo_full_s;

  assign begin_aligned_s = begin_addr_i & AlignMask;
  assign end_aligned_s   = end_addr_i & AlignMask;

  // Reads in flight plus buffered words: the sum only grows on a grant,
  // so a raised request can never lose its credit before being granted.
  assign inflight_s   = {1'b0, outstanding_r} + {1'b0, fifo_count_r};
  assign credit_ok_s  = inflight_s < (CntW+1)'(FifoDepth);
  assign start_ok_s   = start_i && (state_r == IDLE);
  assign grant_s      = host_req_o && host_gnt_i;
  assign push_s       = host_rvalid_i;
  assign pop_s        = out_valid_o && out_ready_i;
  assign last_grant_s = grant_s && ((rd_addr_r + WordStep) == stop_addr_r);
  assign fifo_full_s  = fifo_count_r == CntW'(FifoDepth);

  assign host_req_o   = (state_r == FETCH) && credit_ok_s;
  assign host_addr_o  = rd_addr_r;
  assign host_we_o    = 1'b0;
  assign host_be_o    = 4'hF;
  assign host_wdata_o = {DataWidth{1'b0}};

  assign busy_o      = (state_r == FETCH) || (state_r == DRAIN);
  assign done_o      = (state_r == DONE);
  assign err_o       = err_r;
  assign out_valid_o = (fifo_count_r != {CntW{1'b0}});
  assign out_data_o  = mem_r[rptr_r];
  assign out_last_o  = out_valid_o && (state_r == DRAIN) && (inflight_s == (CntW+1)'(1));

  // Next-state decode; DRAIN exits on the final pop so done follows the last handshake directly.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s) begin
          if (begin_aligned_s >= end_aligned_s) begin
            state_next_s = DONE;
          end else begin
            state_next_s = FETCH;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      FETCH: begin
        if (last_grant_s) begin
          state_next_s = DRAIN;
        end else begin
          state_next_s = FETCH;
        end
      end
      DRAIN: begin
        if ((outstanding_r == {CntW{1'b0}}) &&
            ((fifo_count_r == {CntW{1'b0}}) ||
             ((fifo_count_r == CntW'(1)) && pop_s))) begin
          state_next_s = DONE;
        end else begin
          state_next_s = DRAIN;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register and read-address range.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= IDLE;
      rd_addr_r   <= {AddrWidth{1'b0}};
      stop_addr_r <= {AddrWidth{1'b0}};
    end else begin
      state_r <= state_next_s;
      if (start_ok_s) begin
        rd_addr_r   <= begin_aligned_s;
        stop_addr_r <= end_aligned_s;
      end else if (grant_s) begin
        rd_addr_r <= rd_addr_r + WordStep;
      end else begin
        rd_addr_r <= rd_addr_r;
      end
    end
  end

  // Sticky error flag, cleared by an accepted start.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_r <= 1'b0;
    end else if (start_ok_s) begin
      err_r <= 1'b0;
    end else if (push_s && host_err_i) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  // Outstanding-read counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding_r <= {CntW{1'b0}};
    end else begin
      outstanding_r <= outstanding_r + CntW'(grant_s) - CntW'(push_s);
    end
  end

  // Response FIFO; errored responses are stored as zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_r       <= {PtrW{1'b0}};
      rptr_r       <= {PtrW{1'b0}};
      fifo_count_r <= {CntW{1'b0}};
      for (int i = 0; i < FifoDepth; i++) begin
        mem_r[i] <= {DataWidth{1'b0}};
      end
    end else begin
      if (push_s) begin
        mem_r[wptr_r] <= host_err_i ? {DataWidth{1'b0}} : host_rdata_i;
        wptr_r        <= wptr_r + PtrW'(1);
      end
      if (pop_s) begin
        rptr_r <= rptr_r + PtrW'(1);
      end
      fifo_count_r <= fifo_count_r + CntW'(push_s) - CntW'(pop_s);
    end
  end

  riscv_sig_dumper_chk u_chk (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .host_rvalid_i(host_rvalid_i),
    .fifo_full    (fifo_full_s)
  );

endmodule

// Protocol checker: a response must never arrive while the FIFO is full.
module riscv_sig_dumper_chk (
  input logic clk_i,
  input logic rst_i,
  input logic host_rvalid_i,
  input logic fifo_full
);

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(host_rvalid_i && fifo_full));

endmodule

// File: tb/tb_riscv_sig_dumper.sv
// Scoreboard bench for riscv_sig_dumper: a bus responder with a RAM model,
// a stream monitor, and expected words queued when each dump is started.

module tb_riscv_sig_dumper;

  localparam int FifoDepth = 4;

  logic        clk;
  logic        rst_i;
  logic        start_i;
  logic [31:0] begin_addr_i;
  logic [31:0] end_addr_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic        host_req_o;
  logic        host_gnt_i;
  logic [31:0] host_addr_o;
  logic        host_we_o;
  logic [3:0]  host_be_o;
  logic [31:0] host_wdata_o;
  logic        host_rvalid_i;
  logic [31:0] host_rdata_i;
  logic        host_err_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_data_o;
  logic        out_last_o;

  riscv_sig_dumper #(.AddrWidth(32), .DataWidth(32), .FifoDepth(FifoDepth)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .begin_addr_i (begin_addr_i),
    .end_addr_i   (end_addr_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .host_req_o   (host_req_o),
    .host_gnt_i   (host_gnt_i),
    .host_addr_o  (host_addr_o),
    .host_we_o    (host_we_o),
    .host_be_o    (host_be_o),
    .host_wdata_o (host_wdata_o),
    .host_rvalid_i(host_rvalid_i),
    .host_rdata_i (host_rdata_i),
    .host_err_i   (host_err_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_data_o   (out_data_o),
    .out_last_o   (out_last_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] pend_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  int err_at, resp_idx, grants, stall_left, ready_block;
  int done_cnt, cyc, last_cyc, done_cyc;
  logic busy_seen, req_seen;
  logic [31:0] stall_addr;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    if (a >= 32'h1000 && a < 32'h1010) return ((a - 32'h1000) >> 2) + 32'd1;
    return {16'hC0DE, a[15:0]};
  endfunction

  // Bus responder: grants (with optional stall), answers one cycle after grant.
  initial begin
    logic [31:0] ra;
    host_gnt_i = 1'b1; host_rvalid_i = 1'b0; host_rdata_i = 32'h0; host_err_i = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        pend_q.delete();
        host_rvalid_i = 1'b0; host_err_i = 1'b0; host_rdata_i = 32'h0; host_gnt_i = 1'b1;
      end else begin
        if (pend_q.size() > 0) begin
          ra = pend_q.pop_front();
          resp_idx++;
          host_rvalid_i = 1'b1;
          if (resp_idx == err_at) begin
            host_err_i = 1'b1; host_rdata_i = 32'hDEADBEEF;
          end else begin
            host_err_i = 1'b0; host_rdata_i = ram_word(ra);
          end
        end else begin
          host_rvalid_i = 1'b0; host_err_i = 1'b0; host_rdata_i = 32'h0;
        end
        if (stall_left > 0 && grants == 1) begin
          host_gnt_i = 1'b0;
          stall_left--;
          check_eq("stall_req", host_req_o, 1);
          check_eq("stall_addr", host_addr_o, stall_addr);
        end else begin
          host_gnt_i = 1'b1;
        end
        if (host_req_o && host_gnt_i) begin
          if (exp_addr_q.size() == 0) check_eq("extra_req", host_req_o, 0);
          else check_eq("req_addr", host_addr_o, exp_addr_q.pop_front());
          pend_q.push_back(host_addr_o);
          grants++;
        end
      end
    end
  end

  // Stream monitor: drives ready, pops the scoreboard on each handshake.
  initial begin
    exp_t e;
    logic hold_chk;
    logic [31:0] hold_data;
    logic hold_last;
    out_ready_i = 1'b1; hold_chk = 1'b0; hold_data = 32'h0; hold_last = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_i) begin
        out_ready_i = 1'b1;
        hold_chk = 1'b0;
      end else begin
        if (hold_chk) begin
          check_eq("hold_valid", out_valid_o, 1);
          check_eq("hold_data", out_data_o, hold_data);
          check_eq("hold_last", out_last_o, hold_last);
        end
        if (ready_block > 0) begin
          out_ready_i = 1'b0;
          ready_block--;
        end else begin
          out_ready_i = 1'b1;
        end
        if (out_valid_o && out_ready_i) begin
          if (exp_q.size() == 0) check_eq("extra_word", out_valid_o, 0);
          else begin
            e = exp_q.pop_front();
            check_eq("out_data", out_data_o, e.data);
            check_eq("out_last", out_last_o, e.last);
            if (e.last) last_cyc = cyc;
          end
        end
        hold_chk  = out_valid_o && !out_ready_i;
        hold_data = out_data_o;
        hold_last = out_last_o;
        if (done_o) begin done_cnt++; done_cyc = cyc; end
        if (busy_o) busy_seen = 1'b1;
        if (host_req_o) req_seen = 1'b1;
      end
    end
  end

  // Queue expected addresses and words for a dump; returns the word count.
  function automatic int prep(input logic [31:0] b, input logic [31:0] e, input int err_idx);
    logic [31:0] bw, ew;
    int nw;
    exp_t x;
    bw = b & 32'hFFFF_FFFC;
    ew = e & 32'hFFFF_FFFC;
    exp_q.delete();
    exp_addr_q.delete();
    nw = 0;
    for (logic [31:0] a = bw; a < ew; a += 32'd4) begin
      exp_addr_q.push_back(a);
      x.data = (nw + 1 == err_idx) ? 32'h0 : ram_word(a);
      x.last = (a + 32'd4 == ew);
      exp_q.push_back(x);
      nw++;
    end
    err_at = err_idx; resp_idx = 0; grants = 0;
    stall_addr = bw + 32'd4;
    done_cnt = 0; busy_seen = 1'b0; req_seen = 1'b0; last_cyc = -1; done_cyc = -2;
    return nw;
  endfunction

  task automatic run_dump(input logic [31:0] b, input logic [31:0] e, input int err_idx,
                          input int stall, input int block);
    int nw, n;
    logic exp_err;
    @(negedge clk);
    nw = prep(b, e, err_idx);
    exp_err = (err_idx > 0) && (err_idx <= nw);
    stall_left = stall;
    ready_block = block;
    start_i = 1'b1; begin_addr_i = b; end_addr_i = e;
    @(negedge clk);
    start_i = 1'b0;
    check_eq("err_clear", err_o, 0);
    if (nw == 0) begin
      check_eq("empty_done", done_o, 1);
      check_eq("empty_busy", busy_o, 0);
      check_eq("empty_req", host_req_o, 0);
    end else begin
      check_eq("start_busy", busy_o, 1);
      check_eq("start_req", host_req_o, 1);
      if (block > 0) begin
        repeat (15) @(negedge clk);
        check_eq("bp_grants", grants, FifoDepth);
        check_eq("bp_req_low", host_req_o, 0);
      end
      n = 0;
      while (!done_o && n < 500) begin
        @(negedge clk);
        n++;
      end
      check_eq("done_seen", done_o, 1);
    end
    @(negedge clk);
    check_eq("done_pulse", done_o, 0);
    check_eq("busy_end", busy_o, 0);
    check_eq("done_count", done_cnt, 1);
    check_eq("err_end", err_o, exp_err);
    check_eq("words_left", exp_q.size(), 0);
    check_eq("reqs_left", exp_addr_q.size(), 0);
    if (nw > 0) check_eq("done_after_last", done_cyc - last_cyc, 1);
    else begin
      check_eq("empty_busy_seen", busy_seen, 0);
      check_eq("empty_req_seen", req_seen, 0);
    end
  endtask

  initial begin
    int n, nw;
    err_at = 0; resp_idx = 0; grants = 0; stall_left = 0; ready_block = 0;
    done_cnt = 0; cyc = 0; last_cyc = -1; done_cyc = -2;
    busy_seen = 1'b0; req_seen = 1'b0; stall_addr = 32'h0;
    rst_i = 1'b1; start_i = 1'b0; begin_addr_i = 32'h0; end_addr_i = 32'h0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_done", done_o, 0);
    check_eq("rst_err", err_o, 0);
    check_eq("rst_req", host_req_o, 0);
    check_eq("rst_valid", out_valid_o, 0);
    check_eq("rst_last", out_last_o, 0);
    check_eq("rst_addr", host_addr_o, 0);
    check_eq("rst_data", out_data_o, 0);
    check_eq("const_we", host_we_o, 0);
    check_eq("const_be", host_be_o, 4'hF);
    check_eq("const_wdata", host_wdata_o, 0);
    rst_i = 1'b0;

    run_dump(32'h1000, 32'h1010, 0, 0, 0);   // basic
    run_dump(32'h2000, 32'h2000, 0, 0, 0);   // empty range
    run_dump(32'h3000, 32'h2000, 0, 0, 0);   // begin above end
    run_dump(32'h1000, 32'h1020, 0, 0, 20);  // backpressure
    run_dump(32'h1000, 32'h1010, 0, 5, 0);   // grant stall
    run_dump(32'h1000, 32'h1010, 3, 0, 0);   // bus error on 3rd response
    run_dump(32'h1003, 32'h1011, 0, 0, 0);   // low address bits ignored, err cleared
    run_dump(32'h4000, 32'h4004, 0, 0, 0);   // single word

    // Reset in the middle of a fetch, after two grants.
    @(negedge clk);
    nw = prep(32'h1000, 32'h1020, 0);
    stall_left = 0;
    start_i = 1'b1; begin_addr_i = 32'h1000; end_addr_i = 32'h1020;
    @(negedge clk);
    start_i = 1'b0;
    n = 0;
    while (grants < 2 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("rst_mid_grants", grants, 2);
    rst_i = 1'b1;
    @(posedge clk); #1;
    check_eq("mid_busy", busy_o, 0);
    check_eq("mid_done", done_o, 0);
    check_eq("mid_err", err_o, 0);
    check_eq("mid_req", host_req_o, 0);
    check_eq("mid_valid", out_valid_o, 0);
    check_eq("mid_last", out_last_o, 0);
    check_eq("mid_addr", host_addr_o, 0);
    check_eq("mid_data", out_data_o, 0);
    rst_i = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    run_dump(32'h1000, 32'h1020, 0, 0, 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_sig_dumper.md
# riscv_sig_dumper

Bus-host block that reads the RISC-V compliance signature region out of RAM once a test has finished. It is driven by the test utility: a start pulse with begin/end addresses. It sits on a `bus` host port alongside the core and the test utility, issues word-read requests, buffers the responses in a small FIFO, and streams the words over a valid/ready interface to the simulator-side signature writer.

## Interface
Parameters:
- `AddrWidth`, 32, address width of host port and range inputs
- `DataWidth`, 32, data width; fixed at 32 (word granularity)
- `FifoDepth`, 4, response buffer entries (power of 2, ≥2); also bounds outstanding reads

Ports:
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset; synchronous, active-high
- `start_i`  in  1  one-cycle start pulse; ignored while `busy_o`
- `begin_addr_i`  in  AddrWidth  first word address (inclusive); bits [1:0] ignored; sampled on accepted start
- `end_addr_i`  in  AddrWidth  end word address (exclusive); bits [1:0] ignored; sampled on accepted start
- `busy_o`  out  1  high from cycle after accepted start until `done_o`
- `done_o`  out  1  one-cycle pulse when dump complete
- `err_o`  out  1  sticky: any `host_err_i` seen this dump; cleared on next accepted start
- `host_req_o`  out  1  bus request
- `host_gnt_i`  in  1  bus grant
- `host_addr_o`  out  AddrWidth  word-aligned read address
- `host_we_o`  out  1  constant 0
- `host_be_o`  out  4  constant 4'hF
- `host_wdata_o`  out  32  constant 0
- `host_rvalid_i`  in  1  read response valid
- `host_rdata_i`  in  32  read data
- `host_err_i`  in  1  response error, qualified by `host_rvalid_i`
- `out_valid_o`  out  1  stream word valid
- `out_ready_i`  in  1  stream consumer ready
- `out_data_o`  out  32  signature word
- `out_last_o`  out  1  final word of dump, qualified by `out_valid_o`

## Operation
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE: `start_i` latches `rd_addr = begin & ~3`, `stop = end & ~3`, clears `err_o`.
  - If `rd_addr >= stop`, go to DONE; no bus traffic.
  - Otherwise go to FETCH.
- FETCH: assert `host_req_o` with `host_addr_o = rd_addr` while `outstanding + fifo_count < FifoDepth`.
  - Once asserted, `host_req_o` and `host_addr_o` hold until `host_gnt_i`.
  - On grant: `rd_addr += 4` and `outstanding++`.
  - When the granted address was `stop - 4`, go to DRAIN.
- DRAIN: no requests; wait until `outstanding == 0` and FIFO empty, then go to DONE.
- DONE: `done_o = 1` for one cycle, then IDLE.
- Response handling, any state:
  - `host_rvalid_i` decrements `outstanding` and pushes `host_rdata_i` into the FIFO.
  - If `host_err_i` is set, push 32'h0 instead and set `err_o`.
- `out_last_o` is high on the head word when no more requests remain and `outstanding + fifo_count == 1`.
- Range arithmetic is unsigned AddrWidth. `rd_addr` never wraps because the bound is checked before each request.
- Credit rule: the FIFO can never overflow. An rvalid arriving while full is an assertion failure.
- Reset mid-dump: everything returns to IDLE, FIFO and counters clear. The bench must not deliver stale rvalids after reset.

## Timing
- Reset values: `busy_o`, `done_o`, `err_o`, `host_req_o`, `out_valid_o`, `out_last_o` = 0; `host_addr_o`, `out_data_o` = 0.
- Start accepted in cycle N:
  - `busy_o` and `host_req_o` are high from cycle N+1.
  - With an empty range, `done_o` fires in N+1 and `busy_o` stays 0.
- Back-to-back grants: one request per cycle while credit is available. Address advances the cycle after grant.
- `host_rvalid_i` in cycle M gives `out_valid_o` in cycle M+1 (registered FIFO).
- Stream side:
  - A word pops on `out_valid_o && out_ready_i`.
  - `out_data_o` and `out_last_o` hold stable while `out_valid_o && !out_ready_i`.
  - Throughput is one word per cycle.
- `done_o` pulses in the cycle after the last-word handshake. `busy_o` drops in the same cycle as `done_o`.

## Test plan
- Basic dump: RAM[0x1000..0x100C] = 1,2,3,4; start with begin=0x1000, end=0x1010, gnt always high, ready always high -> reads 0x1000,0x1004,0x1008,0x100C; stream 1,2,3,4 with last on 4; one `done_o` pulse; `err_o` = 0.
- Empty range: begin=end=0x2000 -> no `host_req_o`; `done_o` in cycle after start; `busy_o` never high.
- Backpressure: 8-word range, `out_ready_i` low for 20 cycles -> exactly FifoDepth (4) requests granted, then `host_req_o` low; after ready rises all 8 words arrive in order, none lost.
- Grant stall: `host_gnt_i` low for 5 cycles on the second request -> `host_req_o` and `host_addr_o` = begin+4 stay stable all 5 cycles; output order preserved.
- Bus error: `host_err_i` on the 3rd response -> 3rd word output 0x0; `err_o` high until next start; dump still completes with `done_o`.
- Reset mid-dump: assert `rst_i` during FETCH after 2 grants -> next cycle all outputs at reset values; a new start then dumps the full range correctly.
